axis_wdata: RTL

AXI write-data channel stage; companion to the write-address stage of the stream-to-memory writer.
- Takes the same element-count configuration as the address stage and the already-packed wide data stream.
- Drives axi_wdata/axi_wvalid/axi_wlast, splitting the transfer into 256-beat bursts plus one shorter final burst.
- Burst boundaries match the addresses issued by the address stage exactly.

---
 rtl/axis_wdata.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_wdata.sv
// AXI write-data channel stage: forwards the packed stream as AXI W beats, cut into
// 256-beat bursts plus a short tail. Define AXIS_WDATA_SKID_EN for a registered 2-entry skid buffer.
module axis_wdata #(
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned WIDTH_RATIO    = 8,
  parameter int unsigned CONVERT_SHIFT  = 3,
  parameter int unsigned AXI_LEN_WIDTH  = 8,
  parameter int unsigned AXI_DATA_WIDTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_length,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [AXI_DATA_WIDTH-1:0]     data,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic                          axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]     axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
  output logic                          axi_wlast,
  output logic                          axi_wvalid
);

  typedef enum logic [3:0] {
    ST_CONFIG = 4'b0001,
    ST_SETUP  = 4'b0010,
    ST_ACTIVE = 4'b0100,
    ST_DONE   = 4'b1000
  } state_t;

  state_t                    state_q, state_d;
  logic [CFG_DWIDTH-1:0]     len_q, len_d;
  logic [CFG_DWIDTH-1:0]     beats_total_q, beats_total_d;
  logic [CFG_DWIDTH-1:0]     beat_cnt_q, beat_cnt_d;
  logic [AXI_LEN_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

  logic [CFG_DWIDTH-1:0]     beats_sum;
  logic [CFG_DWIDTH-1:0]     beats_calc;
  logic [CFG_DWIDTH-1:0]     last_idx;
  logic                      last_beat;
  logic                      wlast_calc;

  // Rounding add wraps at CFG_DWIDTH before the shift, matching the address stage.
  assign beats_sum  = len_q + CFG_DWIDTH'(WIDTH_RATIO - 1);
  assign beats_calc = beats_sum >> CONVERT_SHIFT;
  assign last_idx   = beats_total_q - CFG_DWIDTH'(1);
  assign last_beat  = (beat_cnt_q == last_idx);
  assign wlast_calc = (burst_cnt_q == '1) | last_beat;

  assign cfg_ready  = (state_q == ST_CONFIG);
  assign axi_wstrb  = '1;

`ifdef AXIS_WDATA_SKID_EN
  logic                      out_valid_q, out_valid_d;
  logic [AXI_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic                      skid_valid_q, skid_valid_d;
  logic [AXI_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                      skid_last_q, skid_last_d;
  logic                      rdy_q, rdy_d;
  logic                      in_done_q, in_done_d;
  logic                      in_accept;
  logic                      pop;

  assign in_accept  = data_valid & rdy_q;
  assign pop        = out_valid_q & axi_wready;

  assign data_ready = rdy_q;
  assign axi_wvalid = out_valid_q;
  assign axi_wdata  = out_data_q;
  assign axi_wlast  = out_last_q;
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beats_total_d = beats_total_q;
    beat_cnt_d    = beat_cnt_q;
    burst_cnt_d   = burst_cnt_q;
`ifdef AXIS_WDATA_SKID_EN
    in_done_d     = in_done_q;
`else
    data_ready    = 1'b0;
    axi_wvalid    = 1'b0;
    axi_wlast     = 1'b0;
    axi_wdata     = '0;
`endif
    case (state_q)
      ST_CONFIG: begin
        if (cfg_valid) begin
          len_d   = cfg_length;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        beats_total_d = beats_calc;
        beat_cnt_d    = '0;
        burst_cnt_d   = '0;
`ifdef AXIS_WDATA_SKID_EN
        in_done_d     = 1'b0;
`endif
        state_d       = (beats_calc == '0) ? ST_DONE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
`ifdef AXIS_WDATA_SKID_EN
        // Counters track words entering the buffer; completion waits for the buffer to drain.
        if (in_accept) begin
          beat_cnt_d  = beat_cnt_q + CFG_DWIDTH'(1);
          burst_cnt_d = burst_cnt_q + AXI_LEN_WIDTH'(1);
          if (last_beat) in_done_d = 1'b1;
        end
        if (pop && !skid_valid_q && in_done_q) state_d = ST_DONE;
`else
        axi_wvalid = data_valid;
        data_ready = axi_wready;
        axi_wdata  = data;
        axi_wlast  = wlast_calc;
        if (data_valid && axi_wready) begin
          beat_cnt_d  = beat_cnt_q + CFG_DWIDTH'(1);
          burst_cnt_d = burst_cnt_q + AXI_LEN_WIDTH'(1);
          if (last_beat) state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_CONFIG;
      end
      default: begin
        state_d = ST_CONFIG;
      end
    endcase
  end

`ifdef AXIS_WDATA_SKID_EN
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (pop) begin
      out_valid_d  = skid_valid_q;
      out_data_d   = skid_data_q;
      out_last_d   = skid_last_q;
      skid_valid_d = 1'b0;
    end
    // Incoming word fills the head slot if it is free after the pop, else the skid slot.
    if (in_accept) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_data_d  = data;
        out_last_d  = wlast_calc;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = data;
        skid_last_d  = wlast_calc;
      end
    end
    rdy_d = (state_d == ST_ACTIVE) & ~in_done_d & ~skid_valid_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CONFIG;
      len_q         <= '0;
      beats_total_q <= '0;
      beat_cnt_q    <= '0;
      burst_cnt_q   <= '0;
`ifdef AXIS_WDATA_SKID_EN
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_last_q   <= 1'b0;
      rdy_q         <= 1'b0;
      in_done_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beats_total_q <= beats_total_d;
      beat_cnt_q    <= beat_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
`ifdef AXIS_WDATA_SKID_EN
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_last_q   <= skid_last_d;
      rdy_q         <= rdy_d;
      in_done_q     <= in_done_d;
`endif
    end
  end

endmodule
